// File: rtl/dll_pkg.sv
// Shared DLL definitions: sequence width, DLLP type codes, ack/nak result codes,
// CRC-16 constants and the receive framer state encoding.
package dll_pkg;

    localparam int          SEQ_W       = 12;
    localparam logic [7:0]  ACK_TYPE    = 8'h00;
    localparam logic [7:0]  NAK_TYPE    = 8'h10;

    localparam logic [1:0]  ACKNAK_NONE = 2'b00;
    localparam logic [1:0]  ACKNAK_ACK  = 2'b01;
    localparam logic [1:0]  ACKNAK_NAK  = 2'b10;

    localparam logic [15:0] CRC16_POLY  = 16'h100B;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W1   = 2'd1,
        ST_W2   = 2'd2
    } rx_state_e;

endpackage

// File: rtl/dllp_crc16.sv
// Combinational CRC-16 update over one 16-bit word, MSB first.
module dllp_crc16
    import dll_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (crc_out[15] ^ data[i]) begin
                crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_out = {crc_out[14:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/dllp_ack_nak_rx.sv
// Receive-side ACK/NAK DLLP decoder: frames 3-word DLLPs, checks CRC, validates
// the sequence number against the outstanding window and hands results to replay_buffer.
module dllp_ack_nak_rx
    import dll_pkg::*;
#(
    parameter int          SEQ_W_P  = SEQ_W,
    parameter logic [7:0]  ACK_T    = ACK_TYPE,
    parameter logic [7:0]  NAK_T    = NAK_TYPE,
    parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dllp_valid,
    input  logic               dllp_sop,
    input  logic [15:0]        dllp_data,
    input  logic [SEQ_W_P-1:0] next_tx_seq,
    input  logic               rb_ready,
    output logic [1:0]         ack_nack,
    output logic [SEQ_W_P-1:0] seq,
    output logic [SEQ_W_P-1:0] ackd_seq,
    output logic               ack_progress,
    output logic               crc_err,
    output logic               proto_err,
    output logic [1:0]         dbg_state
);

    localparam logic [SEQ_W_P-1:0] SEQ_ONE = SEQ_W_P'(1);

    rx_state_e          state_q, state_d;
    logic [7:0]         type_q, type_d;
    logic [SEQ_W_P-1:0] rx_seq_q, rx_seq_d;
    logic [15:0]        crc_q, crc_d;
    logic [1:0]         ack_nack_q, ack_nack_d;
    logic [SEQ_W_P-1:0] seq_q, seq_d;
    logic [SEQ_W_P-1:0] ackd_seq_q, ackd_seq_d;
    logic               ack_progress_q, ack_progress_d;
    logic               crc_err_q, crc_err_d;
    logic               proto_err_q, proto_err_d;

    logic [15:0]        crc_in, crc_out;
    logic [SEQ_W_P-1:0] d_s, d_a;
    logic               in_range;

    // A new sop always restarts the CRC from the seed, whatever state we were in.
    assign crc_in = dllp_sop ? CRC_INIT : crc_q;

    dllp_crc16 u_crc (
        .crc_in  (crc_in),
        .data    (dllp_data),
        .crc_out (crc_out)
    );

    assign d_s      = next_tx_seq - SEQ_ONE - rx_seq_q;
    assign d_a      = next_tx_seq - SEQ_ONE - ackd_seq_q;
    assign in_range = (d_s <= d_a);

    always_comb begin
        state_d        = state_q;
        type_d         = type_q;
        rx_seq_d       = rx_seq_q;
        crc_d          = crc_q;
        ack_nack_d     = ack_nack_q;
        seq_d          = seq_q;
        ackd_seq_d     = ackd_seq_q;
        ack_progress_d = 1'b0;
        crc_err_d      = 1'b0;
        proto_err_d    = 1'b0;

        if (rb_ready) begin
            ack_nack_d = ACKNAK_NONE;
        end

        if (dllp_valid) begin
            if (dllp_sop) begin
                crc_err_d = (state_q != ST_IDLE);
                type_d    = dllp_data[15:8];
                crc_d     = crc_out;
                state_d   = ST_W1;
            end else begin
                case (state_q)
                    ST_W1: begin
                        rx_seq_d = dllp_data[SEQ_W_P-1:0];
                        crc_d    = crc_out;
                        state_d  = ST_W2;
                    end
                    ST_W2: begin
                        state_d = ST_IDLE;
                        if (~crc_q != dllp_data) begin
                            crc_err_d = 1'b1;
                        end else if (type_q == ACK_T || type_q == NAK_T) begin
                            if (!in_range) begin
                                proto_err_d = 1'b1;
                            end else if (type_q == NAK_T) begin
                                ack_progress_d = (rx_seq_q != ackd_seq_q);
                                ackd_seq_d     = rx_seq_q;
                                ack_nack_d     = ACKNAK_NAK;
                                seq_d          = rx_seq_q;
                            end else if (rx_seq_q != ackd_seq_q) begin
                                ack_progress_d = 1'b1;
                                ackd_seq_d     = rx_seq_q;
                                ack_nack_d     = ACKNAK_ACK;
                                seq_d          = rx_seq_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            type_q         <= 8'h00;
            rx_seq_q       <= '0;
            crc_q          <= CRC_INIT;
            ack_nack_q     <= ACKNAK_NONE;
            seq_q          <= '0;
            ackd_seq_q     <= '1;
            ack_progress_q <= 1'b0;
            crc_err_q      <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            type_q         <= type_d;
            rx_seq_q       <= rx_seq_d;
            crc_q          <= crc_d;
            ack_nack_q     <= ack_nack_d;
            seq_q          <= seq_d;
            ackd_seq_q     <= ackd_seq_d;
            ack_progress_q <= ack_progress_d;
            crc_err_q      <= crc_err_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign ack_nack     = ack_nack_q;
    assign seq          = seq_q;
    assign ackd_seq     = ackd_seq_q;
    assign ack_progress = ack_progress_q;
    assign crc_err      = crc_err_q;
    assign proto_err    = proto_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dllp_ack_nak_rx.sv
// Directed bench for dllp_ack_nak_rx: a vector table of whole DLLPs plus
// hand-written sequences for hold/overwrite, framing and reset corner cases.
module tb_dllp_ack_nak_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        dllp_valid;
    logic        dllp_sop;
    logic [15:0] dllp_data;
    logic [11:0] next_tx_seq;
    logic        rb_ready;
    logic [1:0]  ack_nack;
    logic [11:0] seq;
    logic [11:0] ackd_seq;
    logic        ack_progress;
    logic        crc_err;
    logic        proto_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dllp_ack_nak_rx dut (
        .clk          (clk),
        .reset        (reset),
        .dllp_valid   (dllp_valid),
        .dllp_sop     (dllp_sop),
        .dllp_data    (dllp_data),
        .next_tx_seq  (next_tx_seq),
        .rb_ready     (rb_ready),
        .ack_nack     (ack_nack),
        .seq          (seq),
        .ackd_seq     (ackd_seq),
        .ack_progress (ack_progress),
        .crc_err      (crc_err),
        .proto_err    (proto_err),
        .dbg_state    (dbg_state)
    );

    typedef struct {
        logic [7:0]  typ;
        logic [11:0] s;
        logic [11:0] nxt;
        bit          flip;
        logic [1:0]  an;
        logic [11:0] sq;
        logic [11:0] ackd;
        bit          prog;
        bit          cerr;
        bit          perr;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h100B;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_word(input logic sop, input logic [15:0] d);
        dllp_valid = 1'b1;
        dllp_sop   = sop;
        dllp_data  = d;
        tick();
    endtask

    task automatic idle_inputs();
        dllp_valid = 1'b0;
        dllp_sop   = 1'b0;
        dllp_data  = 16'h0000;
    endtask

    function automatic logic [15:0] dllp_crc(input logic [7:0] t, input logic [11:0] s);
        return ~crc_step(crc_step(16'hFFFF, {t, 8'h00}), {4'h0, s});
    endfunction

    task automatic send_dllp(input logic [7:0] t, input logic [11:0] s, input bit flip);
        logic [15:0] c;
        c = dllp_crc(t, s);
        if (flip) c[0] = ~c[0];
        drive_word(1'b1, {t, 8'h00});
        drive_word(1'b0, {4'h0, s});
        drive_word(1'b0, c);
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        rb_ready    = 1'b1;
        next_tx_seq = 12'd10;
        idle_inputs();

        // typ, s, next, flip -> ack_nack, seq, ackd_seq, progress, crc_err, proto_err
        vecs[0] = '{8'h00, 12'd5,    12'd10,   1'b0, 2'b01, 12'd5,    12'd5,    1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 12'd7,    12'd10,   1'b1, 2'b00, 12'd0,    12'd5,    1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 12'd12,   12'd10,   1'b0, 2'b00, 12'd0,    12'd5,    1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 12'd5,    12'd10,   1'b0, 2'b00, 12'd0,    12'd5,    1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 12'd6,    12'd10,   1'b0, 2'b00, 12'd0,    12'd5,    1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h10, 12'd5,    12'd10,   1'b0, 2'b10, 12'd5,    12'd5,    1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 12'd4090, 12'd4091, 1'b0, 2'b01, 12'd4090, 12'd4090, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 12'd1,    12'd3,    1'b0, 2'b01, 12'd1,    12'd1,    1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h10, 12'd4094, 12'd3,    1'b0, 2'b00, 12'd0,    12'd1,    1'b0, 1'b0, 1'b1};
        vecs[9] = '{8'h00, 12'd0,    12'd3,    1'b0, 2'b00, 12'd0,    12'd1,    1'b0, 1'b0, 1'b1};

        do_reset();
        check("reset_ackd_seq", ackd_seq, 12'd4095);
        check("reset_ack_nack", ack_nack, 2'b00);
        check("reset_seq", seq, 12'd0);
        check("reset_pulses", {ack_progress, crc_err, proto_err}, 3'b000);
        check("reset_state", dbg_state, 2'd0);

        for (int i = 0; i < 10; i++) begin
            next_tx_seq = vecs[i].nxt;
            send_dllp(vecs[i].typ, vecs[i].s, vecs[i].flip);
            check($sformatf("v%0d_ack_nack", i), ack_nack, vecs[i].an);
            if (vecs[i].an != 2'b00) check($sformatf("v%0d_seq", i), seq, vecs[i].sq);
            check($sformatf("v%0d_ackd_seq", i), ackd_seq, vecs[i].ackd);
            check($sformatf("v%0d_progress", i), ack_progress, vecs[i].prog);
            check($sformatf("v%0d_crc_err", i), crc_err, vecs[i].cerr);
            check($sformatf("v%0d_proto_err", i), proto_err, vecs[i].perr);
            tick();
            check($sformatf("v%0d_cleared", i), ack_nack, 2'b00);
            check($sformatf("v%0d_pulses_low", i), {ack_progress, crc_err, proto_err}, 3'b000);
        end

        // NAK held while replay_buffer is not ready
        do_reset();
        next_tx_seq = 12'd10;
        send_dllp(8'h00, 12'd5, 1'b0);
        tick();
        rb_ready = 1'b0;
        send_dllp(8'h10, 12'd7, 1'b0);
        check("nak_ack_nack", ack_nack, 2'b10);
        check("nak_seq", seq, 12'd7);
        check("nak_ackd_seq", ackd_seq, 12'd7);
        check("nak_progress", ack_progress, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("nak_hold%0d", i), ack_nack, 2'b10);
            check($sformatf("nak_hold_seq%0d", i), seq, 12'd7);
        end
        rb_ready = 1'b1;
        tick();
        check("nak_release", ack_nack, 2'b00);

        // sop re-asserted in W2, then a clean DLLP right behind it
        drive_word(1'b1, {8'h00, 8'h00});
        drive_word(1'b0, 16'h0008);
        drive_word(1'b1, {8'h00, 8'h00});
        check("resop_crc_err", crc_err, 1'b1);
        check("resop_state", dbg_state, 2'd1);
        drive_word(1'b0, 16'h0008);
        drive_word(1'b0, dllp_crc(8'h00, 12'd8));
        idle_inputs();
        check("resop_recover_an", ack_nack, 2'b01);
        check("resop_recover_seq", seq, 12'd8);
        check("resop_recover_crc", crc_err, 1'b0);
        tick();

        // valid without sop in IDLE is ignored
        drive_word(1'b0, 16'h1234);
        idle_inputs();
        check("stray_state", dbg_state, 2'd0);
        check("stray_pulses", {ack_progress, crc_err, proto_err}, 3'b000);

        // back-to-back ACKs while not ready: the later one supersedes
        rb_ready = 1'b0;
        send_dllp(8'h00, 12'd8, 1'b0);
        check("dup_no_forward", ack_nack, 2'b00);
        send_dllp(8'h00, 12'd9, 1'b0);
        check("b2b_first_an", ack_nack, 2'b01);
        check("b2b_first_seq", seq, 12'd9);
        next_tx_seq = 12'd20;
        send_dllp(8'h00, 12'd15, 1'b0);
        check("b2b_second_an", ack_nack, 2'b01);
        check("b2b_second_seq", seq, 12'd15);
        check("b2b_ackd_seq", ackd_seq, 12'd15);
        tick();
        check("b2b_still_held", seq, 12'd15);

        // reset discards pending result and partial DLLP
        drive_word(1'b1, {8'h00, 8'h00});
        drive_word(1'b0, 16'h0011);
        idle_inputs();
        do_reset();
        check("rst_mid_ack_nack", ack_nack, 2'b00);
        check("rst_mid_ackd", ackd_seq, 12'd4095);
        check("rst_mid_state", dbg_state, 2'd0);
        drive_word(1'b0, dllp_crc(8'h00, 12'd17));
        idle_inputs();
        check("rst_mid_no_result", ack_nack, 2'b00);
        check("rst_mid_ackd_after", ackd_seq, 12'd4095);
        rb_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
